mem_access_unit: RTL and testbench

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_unit.sv | 242 ++++++++++++++++++++++++
 tb/tb_mem_access_unit.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - MEM-stage data memory access unit with stall, alignment check and timeout
//
// Purpose:
//   Turns the EX/MEM load/store controls into one data-memory handshake per
//   access. The pipeline is frozen while the access is in flight, and the load
//   result is returned size-selected and sign/zero-extended.
//
// Ports:
//   clk, rst_n                 clock (rising edge), asynchronous active-low reset
//   MemWrite, MemtoReg         store / load request from EX/MEM (store wins if both)
//   Byte, Half                 access size (Byte wins over Half, neither = word)
//   UnsignedExt_Mem            1 = zero-extend load lane, 0 = sign-extend
//   addr, wdata                effective address and store data
//   stall                      freeze for upstream pipeline registers (comb)
//   load_data, load_valid      extended load result and its one-cycle qualifier
//   addr_err                   misaligned access flag (comb, IDLE only)
//   bus_err                    timeout flag, high during the DONE cycle after abort
//   mem_req, mem_we, mem_be    memory request, write enable, byte enables
//   mem_addr, mem_wdata        word-aligned address and lane-replicated store data
//   mem_ack, mem_rdata         memory acknowledge and read data

module mem_access_unit #(
    parameter logic [7:0] TIMEOUT = 8'd255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        MemWrite,
    input  logic        MemtoReg,
    input  logic        Byte,
    input  logic        Half,
    input  logic        UnsignedExt_Mem,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic [31:0] load_data,
    output logic        load_valid,
    output logic        addr_err,
    output logic        bus_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    input  logic        mem_ack,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;

    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [3:0]  mem_be_q, mem_be_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [31:0] load_data_q, load_data_d;
    logic        load_valid_q, load_valid_d;
    logic        bus_err_q, bus_err_d;

    // Load attributes captured with the request so the result path does not
    // depend on EX/MEM contents while waiting for the memory.
    logic        is_load_q, is_load_d;
    logic        sz_byte_q, sz_byte_d;
    logic        sz_half_q, sz_half_d;
    logic        uns_q, uns_d;
    logic [1:0]  lane_q, lane_d;

    // Request decode
    logic        sz_byte, sz_half, sz_word;
    logic        req_any, misaligned, acc;
    logic [3:0]  be_dec;
    logic [31:0] wdata_rep;

    always_comb begin
        sz_byte    = Byte;
        sz_half    = ~Byte & Half;
        sz_word    = ~Byte & ~Half;
        misaligned = (sz_half & addr[0]) | (sz_word & (addr[1:0] != 2'b00));
        req_any    = MemWrite | MemtoReg;
        acc        = req_any & ~misaligned;

        if (sz_byte) begin
            be_dec    = 4'b0001 << addr[1:0];
            wdata_rep = {4{wdata[7:0]}};
        end else if (sz_half) begin
            be_dec    = 4'b0011 << addr[1:0];
            wdata_rep = {2{wdata[15:0]}};
        end else begin
            be_dec    = 4'b1111;
            wdata_rep = wdata;
        end
    end

    // Load lane select and extension from the latched attributes
    logic [7:0]  byte_lane;
    logic [15:0] half_lane;
    logic [31:0] load_ext;

    always_comb begin
        case (lane_q)
            2'd0:    byte_lane = mem_rdata[7:0];
            2'd1:    byte_lane = mem_rdata[15:8];
            2'd2:    byte_lane = mem_rdata[23:16];
            default: byte_lane = mem_rdata[31:24];
        endcase
        half_lane = lane_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];

        if (sz_byte_q) begin
            load_ext = uns_q ? {24'h0, byte_lane} : {{24{byte_lane[7]}}, byte_lane};
        end else if (sz_half_q) begin
            load_ext = uns_q ? {16'h0, half_lane} : {{16{half_lane[15]}}, half_lane};
        end else begin
            load_ext = mem_rdata;
        end
    end

    // Next state and registered outputs
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_be_d     = mem_be_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        load_data_d  = load_data_q;
        load_valid_d = 1'b0;
        bus_err_d    = 1'b0;
        is_load_d    = is_load_q;
        sz_byte_d    = sz_byte_q;
        sz_half_d    = sz_half_q;
        uns_d        = uns_q;
        lane_d       = lane_q;

        case (state_q)
            IDLE: begin
                if (acc) begin
                    state_d     = WAIT;
                    cnt_d       = 8'd0;
                    mem_req_d   = 1'b1;
                    mem_we_d    = MemWrite;
                    mem_be_d    = be_dec;
                    mem_addr_d  = {addr[31:2], 2'b00};
                    mem_wdata_d = wdata_rep;
                    is_load_d   = MemtoReg & ~MemWrite;
                    sz_byte_d   = sz_byte;
                    sz_half_d   = sz_half;
                    uns_d       = UnsignedExt_Mem;
                    lane_d      = addr[1:0];
                end
            end

            WAIT: begin
                if (mem_ack || (cnt_q == TIMEOUT)) begin
                    // Request side is released when the access completes so an
                    // idle unit presents a quiet bus.
                    state_d      = DONE;
                    mem_req_d    = 1'b0;
                    mem_we_d     = 1'b0;
                    mem_be_d     = 4'b0000;
                    mem_addr_d   = 32'h0;
                    mem_wdata_d  = 32'h0;
                    load_valid_d = is_load_q;
                    if (mem_ack) begin
                        if (is_load_q) begin
                            load_data_d = load_ext;
                        end
                    end else begin
                        bus_err_d   = 1'b1;
                        load_data_d = 32'h0;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= 8'd0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_be_q     <= 4'b0000;
            mem_addr_q   <= 32'h0;
            mem_wdata_q  <= 32'h0;
            load_data_q  <= 32'h0;
            load_valid_q <= 1'b0;
            bus_err_q    <= 1'b0;
            is_load_q    <= 1'b0;
            sz_byte_q    <= 1'b0;
            sz_half_q    <= 1'b0;
            uns_q        <= 1'b0;
            lane_q       <= 2'd0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_be_q     <= mem_be_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            load_data_q  <= load_data_d;
            load_valid_q <= load_valid_d;
            bus_err_q    <= bus_err_d;
            is_load_q    <= is_load_d;
            sz_byte_q    <= sz_byte_d;
            sz_half_q    <= sz_half_d;
            uns_q        <= uns_d;
            lane_q       <= lane_d;
        end
    end

    // DONE drops stall so EX/MEM advances on the edge that returns us to IDLE.
    assign stall      = rst_n & (((state_q == IDLE) & acc) | (state_q == WAIT));
    assign addr_err   = rst_n & (state_q == IDLE) & req_any & misaligned;

    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign mem_be     = mem_be_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign load_data  = load_data_q;
    assign load_valid = load_valid_q;
    assign bus_err    = bus_err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - self-checking bench for mem_access_unit
module tb_mem_access_unit;

    localparam int WAIT_LIMIT = 256;  // TIMEOUT + 1 WAIT cycles at the default TIMEOUT

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        MemWrite = 1'b0, MemtoReg = 1'b0, Byte = 1'b0, Half = 1'b0, UnsignedExt_Mem = 1'b0;
    logic [31:0] addr = 32'h0, wdata = 32'h0;
    logic        stall, load_valid, addr_err, bus_err, mem_req, mem_we;
    logic [31:0] load_data, mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = 32'h0;

    mem_access_unit dut (
        .clk(clk), .rst_n(rst_n), .MemWrite(MemWrite), .MemtoReg(MemtoReg),
        .Byte(Byte), .Half(Half), .UnsignedExt_Mem(UnsignedExt_Mem),
        .addr(addr), .wdata(wdata), .stall(stall), .load_data(load_data),
        .load_valid(load_valid), .addr_err(addr_err), .bus_err(bus_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_ack(mem_ack),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    logic [31:0] exp_q[$];

    // Observations gathered by run_access
    int          n_stall, n_req, n_valid, n_berr;
    logic        stable, o_done, o_we;
    logic [3:0]  o_be;
    logic [31:0] o_addr, o_wd;

    // Scoreboard: every load_valid pops the expected result pushed at stimulus time.
    always @(negedge clk) begin
        if (load_valid === 1'b1) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL sb_unexpected_valid: load_valid=1 load_data=%08h, required no result", load_data);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                if (load_data !== e) begin
                    fails++;
                    $display("FAIL sb_load_data: got %08h, required %08h", load_data, e);
                end
            end
        end
    end

    task automatic set_bubble();
        MemWrite = 1'b0; MemtoReg = 1'b0; Byte = 1'b0; Half = 1'b0;
        UnsignedExt_Mem = 1'b0; addr = 32'h0; wdata = 32'h0;
    endtask

    // Plays the memory: acks in WAIT cycle number ack_at (0 = never), records
    // what the DUT did, and retires the instruction (bubble) during DONE.
    task automatic run_access(input int ack_at, input logic [31:0] rdata);
        int   wcnt;
        logic seen;
        n_stall = 0; n_valid = 0; n_berr = 0; wcnt = 0; seen = 1'b0;
        stable = 1'b1; o_done = 1'b0; o_we = 1'b0; o_be = 4'h0; o_addr = 32'h0; o_wd = 32'h0;
        for (int c = 0; c < 600 && !o_done; c++) begin
            #1;
            if (stall === 1'b1) n_stall++;
            if (load_valid === 1'b1) n_valid++;
            if (bus_err === 1'b1) n_berr++;
            if (mem_req === 1'b1) begin
                wcnt++;
                seen = 1'b1;
                if (wcnt == 1) begin
                    o_we = mem_we; o_be = mem_be; o_addr = mem_addr; o_wd = mem_wdata;
                end else if (mem_we !== o_we || mem_be !== o_be || mem_addr !== o_addr || mem_wdata !== o_wd) begin
                    stable = 1'b0;
                end
                mem_ack   = (wcnt == ack_at);
                mem_rdata = (wcnt == ack_at) ? rdata : 32'h5A5A_0BAD;
            end else begin
                mem_ack = 1'b0;
                if (seen) begin
                    o_done = 1'b1;
                    set_bubble();
                end
            end
            @(negedge clk);
        end
        n_req   = wcnt;
        mem_ack = 1'b0;
    endtask

    task automatic test_reset();
        MemtoReg = 1'b1; addr = 32'h0000_4002;   // misaligned word while in reset
        repeat (2) @(negedge clk);
        #1;
        tests++;
        if (stall !== 1'b0 || addr_err !== 1'b0) begin
            fails++;
            $display("FAIL reset_comb: stall=%b addr_err=%b, required 0 0", stall, addr_err);
        end
        addr = 32'h0000_1000;                    // aligned load while in reset
        #1;
        tests++;
        if (stall !== 1'b0) begin
            fails++;
            $display("FAIL reset_stall: stall=%b, required 0", stall);
        end
        tests++;
        if ({mem_req, mem_we, mem_be, load_valid, bus_err} !== 8'h00 ||
            mem_addr !== 32'h0 || mem_wdata !== 32'h0 || load_data !== 32'h0) begin
            fails++;
            $display("FAIL reset_regs: req=%b we=%b be=%b lv=%b be_err=%b addr=%08h wd=%08h ld=%08h, required all 0",
                     mem_req, mem_we, mem_be, load_valid, bus_err, mem_addr, mem_wdata, load_data);
        end
        set_bubble();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_bubble();
        mem_ack = 1'b1;                          // stray ack outside WAIT
        mem_rdata = 32'hFFFF_FFFF;
        for (int c = 0; c < 3; c++) begin
            #1;
            tests++;
            if ({stall, addr_err, mem_req, mem_we, mem_be, load_valid, bus_err} !== 10'h0 || load_data !== 32'h0) begin
                fails++;
                $display("FAIL bubble_c%0d: stall=%b ae=%b req=%b we=%b be=%b lv=%b berr=%b ld=%08h, required all 0",
                         c, stall, addr_err, mem_req, mem_we, mem_be, load_valid, bus_err, load_data);
            end
            @(negedge clk);
        end
        mem_ack = 1'b0;
    endtask

    task automatic test_lb();
        MemtoReg = 1'b1; Byte = 1'b1; addr = 32'h0000_1003;
        exp_q.push_back(32'hFFFF_FF80);
        run_access(1, 32'h80FF_FF7F);
        tests++;
        if (!o_done || n_stall != 2 || n_req != 1 || n_valid != 1) begin
            fails++;
            $display("FAIL lb_timing: done=%b stall=%0d req=%0d valid=%0d, required 1 2 1 1", o_done, n_stall, n_req, n_valid);
        end
        tests++;
        if (o_be !== 4'b1000 || o_we !== 1'b0 || o_addr !== 32'h0000_1000) begin
            fails++;
            $display("FAIL lb_req: be=%b we=%b addr=%08h, required 1000 0 00001000", o_be, o_we, o_addr);
        end
    endtask

    task automatic test_lhu();
        MemtoReg = 1'b1; Half = 1'b1; UnsignedExt_Mem = 1'b1; addr = 32'h0000_2002;
        exp_q.push_back(32'h0000_BEEF);
        run_access(1, 32'hBEEF_1234);
        tests++;
        if (!o_done || o_be !== 4'b1100 || o_addr !== 32'h0000_2000 || n_valid != 1) begin
            fails++;
            $display("FAIL lhu: done=%b be=%b addr=%08h valid=%0d, required 1 1100 00002000 1", o_done, o_be, o_addr, n_valid);
        end
    endtask

    task automatic test_lbu_lh();
        MemtoReg = 1'b1; Byte = 1'b1; UnsignedExt_Mem = 1'b1; addr = 32'h0000_1001;
        exp_q.push_back(32'h0000_00FF);
        run_access(2, 32'h80FF_FF7F);
        tests++;
        if (!o_done || o_be !== 4'b0010 || n_stall != 3) begin
            fails++;
            $display("FAIL lbu: done=%b be=%b stall=%0d, required 1 0010 3", o_done, o_be, n_stall);
        end
        MemtoReg = 1'b1; Half = 1'b1; addr = 32'h0000_7000;
        exp_q.push_back(32'hFFFF_8001);
        run_access(1, 32'h1234_8001);
        tests++;
        if (!o_done || o_be !== 4'b0011 || n_valid != 1) begin
            fails++;
            $display("FAIL lh: done=%b be=%b valid=%0d, required 1 0011 1", o_done, o_be, n_valid);
        end
    endtask

    task automatic test_sb();
        MemWrite = 1'b1; Byte = 1'b1; addr = 32'h0000_3001; wdata = 32'h0000_00A5;
        run_access(5, 32'h0);
        tests++;
        if (!o_done || n_req != 5 || n_stall != 6 || n_valid != 0 || !stable) begin
            fails++;
            $display("FAIL sb_timing: done=%b req=%0d stall=%0d valid=%0d stable=%b, required 1 5 6 0 1",
                     o_done, n_req, n_stall, n_valid, stable);
        end
        tests++;
        if (o_we !== 1'b1 || o_be !== 4'b0010 || o_wd !== 32'hA5A5_A5A5 || o_addr !== 32'h0000_3000) begin
            fails++;
            $display("FAIL sb_req: we=%b be=%b wd=%08h addr=%08h, required 1 0010 a5a5a5a5 00003000", o_we, o_be, o_wd, o_addr);
        end
        tests++;
        if (load_data !== 32'hFFFF_8001) begin
            fails++;
            $display("FAIL sb_load_data_held: got %08h, required ffff8001", load_data);
        end
    endtask

    task automatic test_store_priority();
        MemWrite = 1'b1; MemtoReg = 1'b1; addr = 32'h0000_6000; wdata = 32'hDEAD_BEEF;
        run_access(2, 32'h0);
        tests++;
        if (!o_done || o_we !== 1'b1 || o_be !== 4'b1111 || o_wd !== 32'hDEAD_BEEF || n_valid != 0) begin
            fails++;
            $display("FAIL sw_priority: done=%b we=%b be=%b wd=%08h valid=%0d, required 1 1 1111 deadbeef 0",
                     o_done, o_we, o_be, o_wd, n_valid);
        end
    endtask

    task automatic test_misaligned();
        MemtoReg = 1'b1; addr = 32'h0000_4002;
        for (int c = 0; c < 3; c++) begin
            #1;
            tests++;
            if (addr_err !== 1'b1 || stall !== 1'b0 || mem_req !== 1'b0 || load_valid !== 1'b0) begin
                fails++;
                $display("FAIL lw_misaligned_c%0d: ae=%b stall=%b req=%b lv=%b, required 1 0 0 0", c, addr_err, stall, mem_req, load_valid);
            end
            @(negedge clk);
        end
        Half = 1'b1; addr = 32'h0000_4001;
        #1;
        tests++;
        if (addr_err !== 1'b1 || stall !== 1'b0) begin
            fails++;
            $display("FAIL lh_misaligned: ae=%b stall=%b, required 1 0", addr_err, stall);
        end
        set_bubble();
        @(negedge clk);
        #1;
        tests++;
        if (mem_req !== 1'b0 || addr_err !== 1'b0) begin
            fails++;
            $display("FAIL misaligned_after: req=%b ae=%b, required 0 0", mem_req, addr_err);
        end
        @(negedge clk);
    endtask

    task automatic test_timeout();
        MemtoReg = 1'b1; addr = 32'h0000_8000;
        exp_q.push_back(32'h0000_0000);
        run_access(0, 32'h0);
        tests++;
        if (!o_done || n_req != WAIT_LIMIT || n_berr != 1) begin
            fails++;
            $display("FAIL timeout: done=%b wait=%0d bus_err=%0d, required 1 %0d 1", o_done, n_req, n_berr, WAIT_LIMIT);
        end
        #1;
        tests++;
        if (load_data !== 32'h0 || bus_err !== 1'b0 || stall !== 1'b0 || mem_req !== 1'b0) begin
            fails++;
            $display("FAIL timeout_idle: ld=%08h berr=%b stall=%b req=%b, required 0 0 0 0", load_data, bus_err, stall, mem_req);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_wait();
        int c;
        MemtoReg = 1'b1; addr = 32'h0000_5000;
        c = 0;
        #1;
        while (mem_req !== 1'b1 && c < 5) begin
            @(negedge clk);
            #1;
            c++;
        end
        tests++;
        if (mem_req !== 1'b1) begin
            fails++;
            $display("FAIL rstwait_enter: req=%b, required 1", mem_req);
        end
        #1 rst_n = 1'b0;
        #1;
        tests++;
        if (mem_req !== 1'b0 || stall !== 1'b0) begin
            fails++;
            $display("FAIL rstwait_abort: req=%b stall=%b, required 0 0", mem_req, stall);
        end
        set_bubble();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        MemtoReg = 1'b1; Half = 1'b1; addr = 32'h0000_5002;
        exp_q.push_back(32'hFFFF_8001);
        run_access(1, 32'h8001_0000);
        tests++;
        if (!o_done || n_stall != 2 || n_valid != 1 || o_be !== 4'b1100) begin
            fails++;
            $display("FAIL rstwait_next: done=%b stall=%0d valid=%0d be=%b, required 1 2 1 1100", o_done, n_stall, n_valid, o_be);
        end
    endtask

    initial begin
        test_reset();
        test_bubble();
        test_lb();
        test_lhu();
        test_lbu_lh();
        test_sb();
        test_store_priority();
        test_misaligned();
        test_timeout();
        test_reset_wait();
        repeat (2) @(negedge clk);
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL sb_drain: %0d results outstanding, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
